iq_channel_scheduler: RTL and testbench
=======================================

# iq_channel_scheduler

Time-multiplexes up to four IQ demodulator channels onto the single DAC_DB output path. It round-robins (or holds a manually chosen channel), inserts a programmable filter-settle blank after every switch, and presents a registered I-or-Q sample with a valid flag and a frame marker for scope triggering. It sits between the IQModule instances and the signed-to-unsigned DAC converter, replacing the switch-driven mux chain.

## Interface
Parameters:
- N, 14, sample width in bits (signed).
- SETTLE_CYCLES, 1024, blanking cycles after each channel switch (≥1).
- DWELL_CYCLES, 50000, cycles each channel is output in scan mode (≥1).

Ports:
- CLK  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scheduler run; low forces IDLE.
- manual  in  1  1 = hold manualSel, 0 = round-robin scan.
- manualSel  in  2  channel index used in manual mode.
- chanMask  in  4  scan-enable per channel; bit k = channel k.
- qSel  in  1  0 = output I, 1 = output Q.
- chI  in  4*N  I samples, channel k at [k*N +: N].
- chQ  in  4*N  Q samples, same packing.
- chValid  in  4  filter-valid per channel.
- sel  out  2  currently selected channel.
- dataOut  out  N  registered signed sample.
- dataValid  out  1  high while dataOut carries live data.
- frameStart  out  1  one-cycle pulse at start of each scan frame.
- busy  out  1  high when not in IDLE.

## Operation
- States: IDLE, SETTLE, DWELL. A single 32-bit counter is shared between SETTLE and DWELL.
- Reset: state IDLE, sel=0, counter=0, dataOut=0, dataValid=0, frameStart=0, busy=0.
- Target channel: in manual mode, manualSel (chanMask ignored). In scan mode, the lowest set bit of chanMask on entry; on each advance, the next set bit above sel, wrapping 3→0.
- IDLE → SETTLE when enable=1 and (manual=1 or chanMask≠0). sel loads the target channel and the counter clears.
- SETTLE: dataOut=0, dataValid=0. The counter increments to SETTLE_CYCLES-1, then saturates. Go to DWELL when the counter is saturated and chValid[sel]=1; otherwise remain in SETTLE.
- DWELL: dataOut = qSel ? chQ[sel] : chI[sel]; dataValid=1. In scan mode, when the counter reaches DWELL_CYCLES-1, advance sel and enter SETTLE.
- Single enabled channel in scan mode: on reaching DWELL_CYCLES-1, the counter restarts and the block stays in DWELL. No re-settle occurs.
- Manual DWELL is unbounded. A change of manualSel (compared against sel) sends the block to SETTLE with the new sel the next cycle.
- Mode toggles (manual 0↔1) mid-operation: re-enter SETTLE with the new target.
- chanMask clears the current sel bit in scan mode: advance to the next enabled channel via SETTLE on the next cycle.
- enable=0, or chanMask=0 in scan mode: go to IDLE next cycle. dataOut=0, dataValid=0, and sel holds.
- chValid[sel] falls during DWELL: dataValid=0 and dataOut holds its last value. The state is unchanged.
- frameStart pulses for one cycle on entry to DWELL of the lowest enabled channel (scan mode) or on every DWELL entry (manual mode).

## Timing
- All outputs are registered. dataOut and dataValid lag the selected input by 1 cycle.
- Switch cost: 1 transition cycle + SETTLE_CYCLES + any chValid wait.
- Scan period with k channels and chValid high: k·(DWELL_CYCLES + SETTLE_CYCLES) cycles.
- qSel takes effect on dataOut 1 cycle after it changes, with no settle.
- Reset has priority over every other input in the same cycle.

## Configuration
- IQ_SCHED_MARKER_EN defined: during SETTLE, dataOut is driven to the most-positive value (2^(N-1)-1), marking switches on the DAC trace. dataValid is still 0.
- IQ_SCHED_MARKER_EN undefined: dataOut=0 during SETTLE.

## Test plan
- Reset then enable=1, scan, chanMask=4'b0101, SETTLE_CYCLES=4, DWELL_CYCLES=8, chValid=4'hF → sel sequence 0,2,0; each DWELL lasts 8 cycles with dataValid=1; frameStart fires only on channel 0 DWELL entry.
- Same setup with chValid[2]=0 held 20 cycles past settle → stays in SETTLE with sel=2 and dataValid=0; DWELL is entered 2 cycles after chValid[2] rises (1 to detect, 1 registered).
- Manual mode, manualSel 1→3 during DWELL → SETTLE for 4 cycles, then dataOut=chI[3]; setting qSel=1 gives chQ[3] 1 cycle later.
- chanMask=4'b0010 in scan → DWELL on channel 1 persists across multiple DWELL_CYCLES boundaries with no SETTLE entry.
- enable dropped mid-DWELL, then a reset pulse mid-SETTLE → IDLE next cycle with dataOut=0; after reset, all outputs are 0 and sel=0.
- With IQ_SCHED_MARKER_EN and N=14 → dataOut=8191 throughout every SETTLE; without it, dataOut=0.

Source files
------------

// File: rtl/iq_channel_scheduler_if.sv
// ---------------------------------------------------------------------------
// iq_channel_scheduler_if
//   Sample bus between the IQ demodulator channels, the channel scheduler and
//   the DAC_DB converter.
//
//   chI / chQ   : four packed signed N-bit samples, channel k at [k*N +: N]
//   chValid     : per-channel filter-valid flags
//   dataOut     : registered signed sample presented to the DAC path
//   dataValid   : dataOut carries live data
//   frameStart  : one-cycle scope-trigger pulse at the start of a scan frame
//
//   master : scheduler side (consumes channels, drives the DAC path)
//   slave  : channel/DAC side
// ---------------------------------------------------------------------------
interface iq_channel_scheduler_if #(
    parameter int N = 14
);
    logic [4*N-1:0]      chI;
    logic [4*N-1:0]      chQ;
    logic [3:0]          chValid;
    logic signed [N-1:0] dataOut;
    logic                dataValid;
    logic                frameStart;

    modport master (
        input  chI,
        input  chQ,
        input  chValid,
        output dataOut,
        output dataValid,
        output frameStart
    );

    modport slave (
        output chI,
        output chQ,
        output chValid,
        input  dataOut,
        input  dataValid,
        input  frameStart
    );
endinterface

// File: rtl/iq_channel_scheduler.sv
// ---------------------------------------------------------------------------
// iq_channel_scheduler
//   Time-multiplexes up to four IQ demodulator channels onto the single
//   DAC_DB output path. Round-robins over the channels enabled in chanMask
//   (or holds manualSel in manual mode), blanks the output for SETTLE_CYCLES
//   after every switch while the demodulator filter settles, and presents a
//   registered I-or-Q sample with a valid flag and a frame marker.
//
//   Ports:
//     CLK        system clock (CLOCK_50)
//     reset      synchronous, active-high
//     enable     run; low forces IDLE
//     manual     1 = hold manualSel, 0 = round-robin scan
//     manualSel  channel used in manual mode
//     chanMask   scan-enable per channel (bit k = channel k)
//     qSel       0 = output I, 1 = output Q
//     sel        currently selected channel
//     busy       high when not IDLE
//     bus        sample interface (chI, chQ, chValid in; dataOut, dataValid,
//                frameStart out)
//
//   Configuration macro:
//     IQ_SCHED_MARKER_EN  when defined, dataOut is driven to the most-positive
//                         value during SETTLE so switches are visible on the
//                         DAC trace; otherwise dataOut is 0 during SETTLE.
// ---------------------------------------------------------------------------
module iq_channel_scheduler #(
    parameter int          N             = 14,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned DWELL_CYCLES  = 50000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic        manual,
    input  logic [1:0]  manualSel,
    input  logic [3:0]  chanMask,
    input  logic        qSel,
    output logic [1:0]  sel,
    output logic        busy,
    iq_channel_scheduler_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);

`ifdef IQ_SCHED_MARKER_EN
    localparam logic signed [N-1:0] SETTLE_FILL = {1'b0, {(N-1){1'b1}}};
`else
    localparam logic signed [N-1:0] SETTLE_FILL = '0;
`endif

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [1:0]          sel_d;
    logic                mode_q;
    logic                arm_q, arm_d;
    logic signed [N-1:0] dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                frame_q;
    logic                busy_d;
    logic signed [N-1:0] smp_i, smp_q;
    logic [1:0]          first_chan;
    logic [1:0]          after_chan;

    // Lowest enabled channel: start of a scan frame.
    function automatic logic [1:0] lowest_chan(input logic [3:0] mask);
        logic [1:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i] && !found) begin
                r     = 2'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur, wrapping 3->0; returns cur
    // itself when it is the only enabled channel.
    function automatic logic [1:0] next_chan(input logic [3:0] mask,
                                             input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = 2'(32'(cur) + i);
            if (mask[idx] && !found) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        first_chan = lowest_chan(chanMask);
        after_chan = next_chan(chanMask, sel);
        smp_i      = bus.chI[int'(sel)*N +: N];
        smp_q      = bus.chQ[int'(sel)*N +: N];
    end

    // ------------------------------------------------------------------
    // State register and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel     <= '0;
            mode_q  <= 1'b0;
            arm_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel     <= sel_d;
            mode_q  <= manual;
            arm_q   <= arm_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            frame_q <= arm_q;
            busy    <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Abort conditions (disable, mode change, manual
    // reselect, scan channel removed) override the SETTLE/DWELL counting.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel;
        case (state_q)
            IDLE: begin
                if (enable && (manual || chanMask != '0)) begin
                    state_d = SETTLE;
                    sel_d   = manual ? manualSel : first_chan;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!enable || (!manual && chanMask == '0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (manual != mode_q) begin
                    state_d = SETTLE;
                    sel_d   = manual ? manualSel : first_chan;
                    cnt_d   = '0;
                end else if (manual && manualSel != sel) begin
                    state_d = SETTLE;
                    sel_d   = manualSel;
                    cnt_d   = '0;
                end else if (!manual && !chanMask[sel]) begin
                    state_d = SETTLE;
                    sel_d   = after_chan;
                    cnt_d   = '0;
                end else if (state_q == SETTLE) begin
                    // Counter saturates at SETTLE_LAST; then wait for chValid.
                    if (cnt_q == SETTLE_LAST) begin
                        if (bus.chValid[sel]) begin
                            state_d = DWELL;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else begin
                    // DWELL: manual mode holds the counter at DWELL_LAST.
                    if (cnt_q == DWELL_LAST) begin
                        if (!manual) begin
                            cnt_d = '0;
                            if (after_chan != sel) begin
                                state_d = SETTLE;
                                sel_d   = after_chan;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The sample stage works from the current state, so
    // dataOut/dataValid trail the state register by one cycle; frameStart
    // goes through arm_q so it coincides with the first valid sample.
    // ------------------------------------------------------------------
    always_comb begin
        dout_d  = dout_q;
        valid_d = 1'b0;
        busy_d  = (state_d != IDLE);
        arm_d   = (state_d == DWELL) && (state_q != DWELL) &&
                  (manual || sel_d == first_chan);
        case (state_q)
            DWELL: begin
                if (bus.chValid[sel]) begin
                    dout_d  = qSel ? smp_q : smp_i;
                    valid_d = 1'b1;
                end
            end
            SETTLE:  dout_d = SETTLE_FILL;
            default: dout_d = '0;
        endcase
    end

    assign bus.dataOut    = dout_q;
    assign bus.dataValid  = valid_q;
    assign bus.frameStart = frame_q;

endmodule

// File: tb/tb_iq_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_iq_channel_scheduler
//   Directed scenarios plus a randomized control phase for
//   iq_channel_scheduler. Channel samples are random every cycle. Expected
//   outputs come from a rule-level model: a phase flag, a countdown of cycles
//   left in the phase, and the selected channel as an integer.
// ---------------------------------------------------------------------------
module tb_iq_channel_scheduler;

    localparam int N  = 14;
    localparam int TS = 4;
    localparam int TD = 8;

`ifdef IQ_SCHED_MARKER_EN
    localparam logic signed [N-1:0] FILL = 14'sd8191;
`else
    localparam logic signed [N-1:0] FILL = '0;
`endif

    logic       CLK = 1'b0;
    logic       reset;
    logic       enable;
    logic       manual;
    logic [1:0] manualSel;
    logic [3:0] chanMask;
    logic       qSel;
    logic [1:0] sel;
    logic       busy;

    iq_channel_scheduler_if #(.N(N)) bus ();

    iq_channel_scheduler #(
        .N            (N),
        .SETTLE_CYCLES(TS),
        .DWELL_CYCLES (TD)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .enable   (enable),
        .manual   (manual),
        .manualSel(manualSel),
        .chanMask (chanMask),
        .qSel     (qSel),
        .sel      (sel),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int n_valid;
    int n_frame;
    bit rand_q;

    logic signed [N-1:0] last_i [4];
    logic signed [N-1:0] last_q [4];

    // Reference model state
    bit                  m_busy;
    bit                  m_dwell;
    int                  m_sel;
    int                  m_left;
    bit                  m_pm;
    bit                  m_arm;
    logic signed [N-1:0] m_dout;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        int r = 0;
        for (int i = 3; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction

    function automatic int next_above(input logic [3:0] m, input int cur);
        for (int step = 1; step <= 4; step++)
            if (m[(cur + step) % 4]) return (cur + step) % 4;
        return cur;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dwell = 0; m_sel = 0; m_left = 0;
        m_pm = 0; m_arm = 0;
    endtask

    task automatic go_settle(input int ch);
        m_busy = 1; m_dwell = 0; m_sel = ch; m_left = TS - 1;
    endtask

    task automatic model_step();
        int n;
        m_arm = 0;
        if (!m_busy) begin
            if (enable && (manual || chanMask != 0))
                go_settle(manual ? int'(manualSel) : lowest(chanMask));
        end else if (!enable || (!manual && chanMask == 0)) begin
            m_busy = 0; m_dwell = 0;
        end else if (manual != m_pm) begin
            go_settle(manual ? int'(manualSel) : lowest(chanMask));
        end else if (manual && int'(manualSel) != m_sel) begin
            go_settle(int'(manualSel));
        end else if (!manual && !chanMask[m_sel]) begin
            go_settle(next_above(chanMask, m_sel));
        end else if (!m_dwell) begin
            if (m_left > 0) m_left--;
            else if (bus.chValid[m_sel]) begin
                m_dwell = 1; m_left = TD - 1;
                m_arm = manual || (m_sel == lowest(chanMask));
            end
        end else begin
            if (m_left > 0) m_left--;
            else if (!manual) begin
                n = next_above(chanMask, m_sel);
                if (n == m_sel) m_left = TD - 1;
                else go_settle(n);
            end
        end
        m_pm = manual;
    endtask

    // One clock: fresh samples, predict, clock, compare.
    task automatic tick();
        logic signed [N-1:0] e_dout;
        logic                e_valid;
        logic                e_frame;
        logic [N-1:0]        r;
        if (rand_q) qSel = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            r = N'($urandom); bus.chI[k*N +: N] = r; last_i[k] = r;
            r = N'($urandom); bus.chQ[k*N +: N] = r; last_q[k] = r;
        end
        e_frame = m_arm;
        e_valid = 1'b0;
        if (reset) begin
            e_dout  = '0;
            e_frame = 1'b0;
            model_reset();
        end else begin
            if (m_busy && m_dwell) begin
                if (bus.chValid[m_sel]) begin
                    e_dout  = qSel ? last_q[m_sel] : last_i[m_sel];
                    e_valid = 1'b1;
                end else begin
                    e_dout = m_dout;
                end
            end else if (m_busy) begin
                e_dout = FILL;
            end else begin
                e_dout = '0;
            end
            model_step();
        end
        m_dout = e_dout;
        @(posedge CLK);
        #1;
        chk("dataOut",    bus.dataOut,    e_dout);
        chk("dataValid",  bus.dataValid,  e_valid);
        chk("frameStart", bus.frameStart, e_frame);
        chk("busy",       busy,           m_busy);
        chk("sel",        sel,            m_sel);
        n_valid += int'(bus.dataValid);
        n_frame += int'(bus.frameStart);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_valid = 0;
        n_frame = 0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; manual = 1'b0; manualSel = '0;
        chanMask = '0; qSel = 1'b0; bus.chValid = 4'hF; rand_q = 1'b0;
        bus.chI = '0; bus.chQ = '0;
        model_reset();
        m_dout = '0;

        // Reset state (enable held high during reset: reset wins)
        enable = 1'b1;
        tick();
        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_valid", bus.dataValid, 0);

        // Scan 0,2,0 with all channels valid
        rand_q = 1'b1;
        chanMask = 4'b0101;
        run(36);
        chk("scan_valid_cycles", n_valid, 23);
        chk("scan_frames", n_frame, 2);

        // Channel 2 held not-valid 20 cycles past settle
        do_reset();
        bus.chValid = 4'b1011;
        run(36);
        chk("wait_sel", sel, 2);
        chk("wait_valid", bus.dataValid, 0);
        bus.chValid = 4'hF;
        tick();
        chk("wait_detect", bus.dataValid, 0);
        tick();
        chk("wait_dwell", bus.dataValid, 1);
        run(10);

        // Manual mode, reselect 1 -> 3, then qSel
        rand_q = 1'b0; qSel = 1'b0;
        manual = 1'b1; manualSel = 2'd1;
        tick();
        chk("man_sel1", sel, 1);
        run(8);
        manualSel = 2'd3;
        tick();
        chk("man_sel3", sel, 3);
        run(4);
        tick();
        chk("man_valid", bus.dataValid, 1);
        chk("man_i3", bus.dataOut, last_i[3]);
        qSel = 1'b1;
        tick();
        chk("man_q3", bus.dataOut, last_q[3]);

        // Single scan channel: dwell repeats with no re-settle
        manual = 1'b0; rand_q = 1'b1;
        do_reset();
        chanMask = 4'b0010;
        run(40);
        chk("single_valid_cycles", n_valid, 35);
        chk("single_frames", n_frame, 1);

        // enable dropped mid-DWELL, reset mid-SETTLE
        enable = 1'b0;
        tick();
        chk("dis_busy", busy, 0);
        tick();
        chk("dis_dout", bus.dataOut, 0);
        enable = 1'b1;
        run(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_dout", bus.dataOut, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);

        // Randomized control
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) enable = ~enable;
            if ($urandom_range(39) == 0) manual = ~manual;
            if ($urandom_range(19) == 0) manualSel = 2'($urandom);
            if ($urandom_range(19) == 0) chanMask = 4'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(7) == 0) bus.chValid[k] = ~bus.chValid[k];
            reset = ($urandom_range(149) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
